bank_pair_reader: RTL and testbench
===================================

BANK_PAIR_READER -- requirements
Module: bank_pair_reader

Interface
REQ-001 SHALL use `DATA_WIDTH (common.svh); default per common.svh; width of tuple_pair_t.first and .second.
REQ-002 SHALL use `BANK_ADDR_WIDTH (aoc5.svh); default per aoc5.svh; width of the bank address.
REQ-003 SHALL use `BANK_DEPTH (aoc5.svh); default per aoc5.svh; maximum pair count, even plus odd banks.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clock  in  1  rising-edge clock.
REQ-005 SHALL have reset  in  1  synchronous active-high reset.
REQ-006 SHALL have start_in  in  1  begin a read pass; sampled only in IDLE.
REQ-007 SHALL have num_pairs_in  in  `BANK_ADDR_WIDTH+1  number of valid pairs, 0..`BANK_DEPTH; captured with start_in.
REQ-008 SHALL have rd_en_out  out  1  bank read strobe.
REQ-009 SHALL have rd_addr_out  out  `BANK_ADDR_WIDTH  even pair index; the even bank returns pair i and the odd bank returns pair i+1.
REQ-010 SHALL have even_data_in, odd_data_in  in  tuple_pair_t  bank read data, valid exactly 1 cycle after rd_en_out.
REQ-011 SHALL have pair_out  out  tuple_pair_t  streamed pair.
REQ-012 SHALL have pair_valid_out  out  1, and pair_ready_in  in  1  valid/ready handshake.
REQ-013 SHALL have busy_out  out  1  high in every state except IDLE.
REQ-014 SHALL have done_out  out  1  one-cycle pulse at pass end.
REQ-015 SHALL have sum_out  out  `DATA_WIDTH+`BANK_ADDR_WIDTH+1  accumulated covered length.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, LOAD, EMIT_EVEN, EMIT_ODD, DONE.
REQ-017 SHALL, in IDLE with start_in=1: capture num_pairs_in; clear the index and sum_out; go to REQ, or to DONE if num_pairs_in=0.
REQ-018 SHALL, in REQ: drive rd_en_out=1 and rd_addr_out=index for exactly one cycle, then go to LOAD.
REQ-019 SHALL, in LOAD: register even_data_in and odd_data_in into a 2-entry buffer, then go to EMIT_EVEN.
REQ-020 SHALL, in EMIT_EVEN: drive pair_valid_out=1 with pair_out=buffer[0].
REQ-021 SHALL, on handshake in EMIT_EVEN: go to EMIT_ODD if index+1<count; otherwise go to DONE.
REQ-022 SHALL, in EMIT_ODD: drive pair_valid_out=1 with pair_out=buffer[1].
REQ-023 SHALL, on handshake in EMIT_ODD: add 2 to the index, then go to REQ if index<count; otherwise go to DONE.
REQ-024 SHALL hold pair_out and pair_valid_out stable while pair_ready_in=0; no pair is dropped or duplicated.
REQ-025 SHALL give latency from start_in to first pair_valid_out = 3 cycles (REQ, LOAD, EMIT_EVEN); each buffered pair is then emitted with zero added wait states.
REQ-026 SHALL, in DONE: pulse done_out=1 for one cycle, then return to IDLE.
REQ-027 SHALL ignore start_in outside IDLE.
REQ-028 SHALL, on each handshake, add second-first+1 to sum_out when second>=first, else add 0; the add is zero-extended and cannot overflow.
REQ-029 SHALL hold sum_out after DONE until the next accepted start_in.
REQ-030 SHALL, for an odd count, never emit the trailing odd-bank entry.
REQ-031 SHALL, for count=`BANK_DEPTH, issue the final read at rd_addr_out=`BANK_DEPTH-2 and never wrap the address.
REQ-032 SHALL drive rd_en_out=0 in all states other than REQ.

Reset
REQ-033 SHALL, when reset=1, drive state=IDLE and all outputs to 0 (rd_en_out, rd_addr_out, pair_out, pair_valid_out, busy_out, done_out, sum_out), and clear the index, count and buffer.
REQ-034 SHALL, when reset is asserted mid-pass, abort the pass at the next edge with no done_out pulse.
REQ-035 SHALL ignore start_in in the cycle where reset=1.

Verification
REQ-036 SHALL cover count=4, pairs (3-5),(10-14),(12-18),(16-20), ready=1 -> reads at 0 and 2; 4 pairs emitted in order; first valid 3 cycles after start; sum_out=3+5+7+5=20; one done_out.
REQ-037 SHALL cover count=3 -> the third pair is emitted, the odd entry at address 2 is never emitted, and the pass ends in DONE.
REQ-038 SHALL cover count=0 -> no rd_en_out, no pair_valid_out, done_out 1 cycle after start, sum_out=0.
REQ-039 SHALL cover random pair_ready_in backpressure on a 16-pair pass -> the output sequence equals the memory order and pair_out is stable while stalled.
REQ-040 SHALL cover pair (9-4) -> it is emitted and contributes 0 to sum_out.
REQ-041 SHALL cover reset in EMIT_ODD -> the next cycle has all outputs 0 with no done_out; a new start then yields a correct full pass.

Source files
------------

// File: rtl/bank_pair_reader.sv
// Streams tuple pairs out of an even/odd bank pair: one read returns two pairs,
// which are emitted in order over a valid/ready port while summing covered length.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 4
`endif
`ifndef BANK_DEPTH
`define BANK_DEPTH 16
`endif

package bank_pair_pkg;
  typedef struct packed {
    logic [`DATA_WIDTH-1:0] first;
    logic [`DATA_WIDTH-1:0] second;
  } tuple_pair_t;
endpackage

// state     | meaning
// IDLE      | waiting for start_in
// REQ       | read strobe for pairs idx and idx+1
// LOAD      | bank data valid, captured into the buffer
// EMIT_EVEN | offering buffer[0]
// EMIT_ODD  | offering buffer[1]
// DONE      | one-cycle done pulse
module bank_pair_reader
  import bank_pair_pkg::*;
(
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       start_in,
  input  logic [`BANK_ADDR_WIDTH:0]                  num_pairs_in,
  output logic                                       rd_en_out,
  output logic [`BANK_ADDR_WIDTH-1:0]                rd_addr_out,
  input  tuple_pair_t                                even_data_in,
  input  tuple_pair_t                                odd_data_in,
  output tuple_pair_t                                pair_out,
  output logic                                       pair_valid_out,
  input  logic                                       pair_ready_in,
  output logic                                       busy_out,
  output logic                                       done_out,
  output logic [`DATA_WIDTH+`BANK_ADDR_WIDTH:0]      sum_out
);
  localparam int AW  = `BANK_ADDR_WIDTH;
  localparam int DW  = `DATA_WIDTH;
  localparam int CW  = AW + 1;
  localparam int LW  = DW + 1;
  localparam int SW  = DW + AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    LOAD,
    EMIT_EVEN,
    EMIT_ODD,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [CW-1:0] idx;
  logic [CW-1:0] count;
  logic [CW-1:0] idx_p1;
  logic [CW-1:0] idx_p2;
  tuple_pair_t buf_even;
  tuple_pair_t buf_odd;
  logic        handshake;
  logic [LW-1:0] pair_len;

  // idx is always even and at most BANK_DEPTH-2, so idx+2 fits in CW bits
  assign idx_p1    = idx + CW'(1);
  assign idx_p2    = idx + CW'(2);
  assign handshake = pair_valid_out && pair_ready_in;

  always_comb begin
    pair_len = '0;
    if (pair_out.second >= pair_out.first) begin
      pair_len = {1'b0, pair_out.second} - {1'b0, pair_out.first} + LW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    rd_en_out      = 1'b0;
    rd_addr_out    = '0;
    pair_valid_out = 1'b0;
    pair_out       = '0;
    busy_out       = (state != IDLE);
    done_out       = 1'b0;
    case (state)
      IDLE: begin
        if (start_in) begin
          state_nxt = (num_pairs_in == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        rd_en_out   = 1'b1;
        rd_addr_out = idx[AW-1:0];
        state_nxt   = LOAD;
      end
      LOAD: begin
        state_nxt = EMIT_EVEN;
      end
      EMIT_EVEN: begin
        pair_valid_out = 1'b1;
        pair_out       = buf_even;
        if (pair_ready_in) begin
          state_nxt = (idx_p1 < count) ? EMIT_ODD : DONE;
        end
      end
      EMIT_ODD: begin
        pair_valid_out = 1'b1;
        pair_out       = buf_odd;
        if (pair_ready_in) begin
          state_nxt = (idx_p2 < count) ? REQ : DONE;
        end
      end
      DONE: begin
        done_out  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx      <= '0;
      count    <= '0;
      buf_even <= '0;
      buf_odd  <= '0;
      sum_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_in) begin
            count   <= num_pairs_in;
            idx     <= '0;
            sum_out <= '0;
          end
        end
        LOAD: begin
          buf_even <= even_data_in;
          buf_odd  <= odd_data_in;
        end
        EMIT_EVEN: begin
          if (handshake) begin
            sum_out <= sum_out + SW'(pair_len);
          end
        end
        EMIT_ODD: begin
          if (handshake) begin
            sum_out <= sum_out + SW'(pair_len);
            idx     <= idx_p2;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bank_pair_reader.sv
// Directed bench for bank_pair_reader: a behavioural even/odd bank model feeds
// the DUT and each scenario task checks the streamed pairs, reads and sum.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 4
`endif
`ifndef BANK_DEPTH
`define BANK_DEPTH 16
`endif

module tb_bank_pair_reader;
  import bank_pair_pkg::*;

  localparam int AW    = `BANK_ADDR_WIDTH;
  localparam int DW    = `DATA_WIDTH;
  localparam int DEPTH = `BANK_DEPTH;
  localparam int CW    = AW + 1;
  localparam int SW    = DW + AW + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          start_in;
  logic [CW-1:0] num_pairs_in;
  logic          rd_en_out;
  logic [AW-1:0] rd_addr_out;
  tuple_pair_t   even_data_in;
  tuple_pair_t   odd_data_in;
  tuple_pair_t   pair_out;
  logic          pair_valid_out;
  logic          pair_ready_in;
  logic          busy_out;
  logic          done_out;
  logic [SW-1:0] sum_out;

  int checks = 0;
  int passed = 0;

  tuple_pair_t mem [DEPTH];
  tuple_pair_t got [$];
  int          addrs [$];
  int          first_valid_e;
  int          done_e;
  int          done_cnt;
  int          stall_err;
  int          valid_cnt;
  bit          timed_out;

  bank_pair_reader dut (
    .clock          (clock),
    .reset          (reset),
    .start_in       (start_in),
    .num_pairs_in   (num_pairs_in),
    .rd_en_out      (rd_en_out),
    .rd_addr_out    (rd_addr_out),
    .even_data_in   (even_data_in),
    .odd_data_in    (odd_data_in),
    .pair_out       (pair_out),
    .pair_valid_out (pair_valid_out),
    .pair_ready_in  (pair_ready_in),
    .busy_out       (busy_out),
    .done_out       (done_out),
    .sum_out        (sum_out)
  );

  always #5 clock = ~clock;

  // bank model: one-cycle read latency, odd bank holds pair addr+1
  always @(posedge clock) begin
    if (rd_en_out) begin
      even_data_in <= mem[int'(rd_addr_out)];
      odd_data_in  <= mem[int'(rd_addr_out) + 1];
    end
  end

  task automatic set_pair(input int i, input int f, input int s);
    mem[i].first  = DW'(f);
    mem[i].second = DW'(s);
  endtask

  task automatic load_count4_mem();
    for (int i = 0; i < DEPTH; i++) set_pair(i, 100 + i, 50);
    set_pair(0, 3, 5);
    set_pair(1, 10, 14);
    set_pair(2, 12, 18);
    set_pair(3, 16, 20);
  endtask

  task automatic run_pass(input int n, input bit rand_ready);
    int          e;
    int          after;
    bit          seen_done;
    bit          prev_stall;
    tuple_pair_t prev_pair;
    got.delete();
    addrs.delete();
    first_valid_e = -1;
    done_e        = -1;
    done_cnt      = 0;
    stall_err     = 0;
    valid_cnt     = 0;
    seen_done     = 0;
    prev_stall    = 0;
    prev_pair     = '0;
    after         = 0;
    pair_ready_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    num_pairs_in  = CW'(n);
    start_in      = 1'b1;
    @(posedge clock);
    #1 start_in = 1'b0;
    e = 1;
    while (after < 3 && e < 600) begin
      @(negedge clock);
      if (rd_en_out) addrs.push_back(int'(rd_addr_out));
      if (pair_valid_out) begin
        valid_cnt++;
        if (first_valid_e < 0) first_valid_e = e;
      end
      if (prev_stall && (!pair_valid_out || pair_out !== prev_pair)) stall_err++;
      prev_stall = pair_valid_out && !pair_ready_in;
      prev_pair  = pair_out;
      if (pair_valid_out && pair_ready_in) got.push_back(pair_out);
      if (done_out) begin
        done_cnt++;
        if (done_e < 0) done_e = e;
        seen_done = 1;
      end
      if (seen_done) after++;
      @(posedge clock);
      #1 e++;
      pair_ready_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    timed_out     = !seen_done;
    pair_ready_in = 1'b1;
  endtask

  task automatic check_stream(input string name, input int n);
    int bad;
    bad = 0;
    checks++;
    if (got.size() !== n) $display("FAIL %s count: got %0d want %0d", name, got.size(), n);
    else passed++;
    for (int i = 0; i < got.size() && i < n; i++) begin
      if (got[i] !== mem[i]) bad++;
    end
    checks++;
    if (bad !== 0) $display("FAIL %s order: %0d pairs differ from memory order", name, bad);
    else passed++;
  endtask

  task automatic check_addrs(input string name, input int n);
    int exp_n;
    int bad;
    exp_n = (n + 1) / 2;
    bad   = 0;
    checks++;
    if (addrs.size() !== exp_n) $display("FAIL %s reads: got %0d want %0d", name, addrs.size(), exp_n);
    else passed++;
    for (int i = 0; i < addrs.size() && i < exp_n; i++) begin
      if (addrs[i] !== 2 * i) bad++;
    end
    checks++;
    if (bad !== 0) $display("FAIL %s read_addr: %0d addresses not 0,2,4..", name, bad);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_in = 1'b1; num_pairs_in = CW'(4); pair_ready_in = 1'b1;
    even_data_in = '0; odd_data_in = '0;
    load_count4_mem();
    @(posedge clock); @(posedge clock);
    @(negedge clock);
    checks++;
    if ({rd_en_out, rd_addr_out, pair_out, pair_valid_out, busy_out, done_out, sum_out} !== '0)
      $display("FAIL reset_outputs: got nonzero outputs busy=%0b sum=%0d", busy_out, sum_out);
    else passed++;
    @(posedge clock);
    #1 reset = 1'b0; start_in = 1'b0;
    @(negedge clock);
    checks++;
    if (busy_out !== 1'b0) $display("FAIL reset_start_ignored: busy got %0b want 0", busy_out);
    else passed++;
  endtask

  task automatic test_count4();
    load_count4_mem();
    run_pass(4, 1'b0);
    checks++;
    if (timed_out !== 1'b0) $display("FAIL c4_timeout: got %0b want 0", timed_out);
    else passed++;
    check_stream("c4", 4);
    check_addrs("c4", 4);
    checks++;
    if (first_valid_e !== 3) $display("FAIL c4_latency: got %0d want 3", first_valid_e);
    else passed++;
    checks++;
    if (sum_out !== SW'(20)) $display("FAIL c4_sum: got %0d want 20", sum_out);
    else passed++;
    checks++;
    if (done_cnt !== 1) $display("FAIL c4_done: got %0d want 1", done_cnt);
    else passed++;
  endtask

  task automatic test_count3();
    load_count4_mem();
    run_pass(3, 1'b0);
    check_stream("c3", 3);
    check_addrs("c3", 3);
    checks++;
    if (done_cnt !== 1) $display("FAIL c3_done: got %0d want 1", done_cnt);
    else passed++;
    checks++;
    if (sum_out !== SW'(15)) $display("FAIL c3_sum: got %0d want 15", sum_out);
    else passed++;
  endtask

  task automatic test_count0();
    run_pass(0, 1'b0);
    checks++;
    if (addrs.size() !== 0) $display("FAIL c0_reads: got %0d want 0", addrs.size());
    else passed++;
    checks++;
    if (valid_cnt !== 0) $display("FAIL c0_valid: got %0d want 0", valid_cnt);
    else passed++;
    checks++;
    if (done_e !== 1 || done_cnt !== 1) $display("FAIL c0_done: cycle %0d count %0d want 1/1", done_e, done_cnt);
    else passed++;
    checks++;
    if (sum_out !== '0) $display("FAIL c0_sum: got %0d want 0", sum_out);
    else passed++;
  endtask

  task automatic test_back_to_back_stall();
    // lengths cycle 1,2,3,4 -> 4*(1+2+3+4) = 40
    for (int i = 0; i < DEPTH; i++) set_pair(i, 3 * i, 3 * i + (i % 4));
    run_pass(DEPTH, 1'b1);
    checks++;
    if (timed_out !== 1'b0) $display("FAIL bp_timeout: got %0b want 0", timed_out);
    else passed++;
    check_stream("bp", DEPTH);
    check_addrs("bp", DEPTH);
    checks++;
    if (stall_err !== 0) $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_err);
    else passed++;
    checks++;
    if (sum_out !== SW'(40)) $display("FAIL bp_sum: got %0d want 40", sum_out);
    else passed++;
    checks++;
    if (done_cnt !== 1) $display("FAIL bp_done: got %0d want 1", done_cnt);
    else passed++;
  endtask

  task automatic test_reverse_pair();
    set_pair(0, 9, 4);
    set_pair(1, 2, 5);
    run_pass(2, 1'b0);
    check_stream("rev", 2);
    checks++;
    if (sum_out !== SW'(4)) $display("FAIL rev_sum: got %0d want 4", sum_out);
    else passed++;
  endtask

  task automatic test_reset_mid_pass();
    int w;
    load_count4_mem();
    pair_ready_in = 1'b0; num_pairs_in = CW'(4); start_in = 1'b1;
    @(posedge clock);
    #1 start_in = 1'b0;
    w = 0;
    @(negedge clock);
    while (!pair_valid_out && w < 10) begin
      @(negedge clock);
      w++;
    end
    checks++;
    if (pair_valid_out !== 1'b1 || pair_out !== mem[0])
      $display("FAIL mid_even: valid %0b first %0d want 1/%0d", pair_valid_out, pair_out.first, mem[0].first);
    else passed++;
    pair_ready_in = 1'b1;
    @(posedge clock);
    #1 pair_ready_in = 1'b0;
    @(negedge clock);
    checks++;
    if (pair_valid_out !== 1'b1 || pair_out !== mem[1])
      $display("FAIL mid_odd: valid %0b first %0d want 1/%0d", pair_valid_out, pair_out.first, mem[1].first);
    else passed++;
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({rd_en_out, rd_addr_out, pair_out, pair_valid_out, busy_out, done_out, sum_out} !== '0)
      $display("FAIL mid_reset_outputs: busy %0b valid %0b done %0b sum %0d want all 0",
               busy_out, pair_valid_out, done_out, sum_out);
    else passed++;
    @(negedge clock);
    checks++;
    if (done_out !== 1'b0 || busy_out !== 1'b0)
      $display("FAIL mid_reset_nodone: done %0b busy %0b want 0/0", done_out, busy_out);
    else passed++;
    pair_ready_in = 1'b1;
    run_pass(4, 1'b0);
    check_stream("after_reset", 4);
    checks++;
    if (sum_out !== SW'(20) || done_cnt !== 1)
      $display("FAIL after_reset_sum: sum %0d done %0d want 20/1", sum_out, done_cnt);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_count4();
    test_count3();
    test_count0();
    test_back_to_back_stall();
    test_reverse_pair();
    test_reset_mid_pass();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
